// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding request on an SRAM-like bus, tagged delivery to IF/ID.
// Optional misaligned-PC trap (AdEL) enabled by defining IF_ALIGN_CHECK_EN.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  output logic        pc_read_ready_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  output logic        stallreq_o,
  output logic [31:0] excepttype_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [31:0] EXC_ADEL_IF = 32'h0000_0010;

  logic [1:0]  state_q, state_d;
  logic        discard_q, discard_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] exc_q, exc_d;
  logic        enter_req;
  logic        pc_misaligned;

`ifdef IF_ALIGN_CHECK_EN
  assign pc_misaligned = (pc_i[1:0] != 2'b00);
`else
  assign pc_misaligned = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    addr_d    = addr_q;
    inst_d    = inst_q;
    pc_d      = pc_q;
    exc_d     = exc_q;
    enter_req = 1'b0;

    case (state_q)
      S_IDLE: begin
        // stall_i is deliberately ignored: CTRL's stall already includes stallreq_o
        if (!flush_i) begin
          enter_req = 1'b1;
        end
      end
      S_REQ: begin
        if (inst_addr_ok_i) begin
          state_d   = S_WAIT;
          discard_d = flush_i;
        end else if (flush_i) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (inst_data_ok_i) begin
          if (discard_q || flush_i) begin
            state_d   = S_IDLE;
            discard_d = 1'b0;
          end else begin
            state_d = S_HOLD;
            inst_d  = inst_rdata_i;
            pc_d    = addr_q;
            exc_d   = '0;
          end
        end else if (flush_i) begin
          discard_d = 1'b1;
        end
      end
      default: begin
        if (flush_i) begin
          state_d = S_IDLE;
          exc_d   = '0;
        end else if (!stall_i) begin
          enter_req = 1'b1;
          exc_d     = '0;
        end
      end
    endcase

    // A misaligned PC skips the bus and presents a nop carrying the AdEL flag
    if (enter_req) begin
      if (pc_misaligned) begin
        state_d = S_HOLD;
        inst_d  = '0;
        pc_d    = pc_i;
        exc_d   = EXC_ADEL_IF;
      end else begin
        state_d = S_REQ;
        addr_d  = pc_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      discard_q <= 1'b0;
      addr_q    <= RESET_PC;
      inst_q    <= '0;
      pc_q      <= RESET_PC;
      exc_q     <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      addr_q    <= addr_d;
      inst_q    <= inst_d;
      pc_q      <= pc_d;
      exc_q     <= exc_d;
    end
  end

  assign inst_req_o      = (state_q == S_REQ);
  assign pc_read_ready_o = inst_req_o && inst_addr_ok_i;
  assign inst_addr_o     = addr_q;
  assign inst_valid_o    = (state_q == S_HOLD);
  assign inst_o          = inst_q;
  assign inst_pc_o       = pc_q;
  assign excepttype_o    = exc_q;
  assign stallreq_o      = !inst_valid_o && !flush_i;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed cycle table, misaligned-PC sequence, and a
// randomized run against a bus/PC-register model with an in-order fetch scoreboard.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_read_ready_o;
  logic        stall_i;
  logic        flush_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i;
  logic        inst_data_ok_i;
  logic [31:0] inst_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        stallreq_o;
  logic [31:0] excepttype_o;

  always #5 clk = ~clk;

  inst_fetch_ctrl #(.RESET_PC(32'hbfc00000)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_i            (pc_i),
    .pc_read_ready_o (pc_read_ready_o),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .inst_req_o      (inst_req_o),
    .inst_addr_o     (inst_addr_o),
    .inst_addr_ok_i  (inst_addr_ok_i),
    .inst_data_ok_i  (inst_data_ok_i),
    .inst_rdata_i    (inst_rdata_i),
    .inst_o          (inst_o),
    .inst_pc_o       (inst_pc_o),
    .inst_valid_o    (inst_valid_o),
    .stallreq_o      (stallreq_o),
    .excepttype_o    (excepttype_o)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_rdy;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic        e_sreq;
    logic        chk_data;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [31:0] pc, input logic st,
                              input logic fl, input logic ao, input logic dk,
                              input logic [31:0] rd, input logic er, input logic [31:0] ea,
                              input logic erdy, input logic ev, input logic [31:0] ei,
                              input logic [31:0] eip, input logic es, input logic ck);
    vec_t v;
    v.rst = r; v.pc = pc; v.stall = st; v.flush = fl; v.aok = ao; v.dok = dk;
    v.rdata = rd; v.e_req = er; v.e_addr = ea; v.e_rdy = erdy; v.e_valid = ev;
    v.e_inst = ei; v.e_ipc = eip; v.e_sreq = es; v.chk_data = ck;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h3c3c_a5a5;
  endfunction

  localparam logic [31:0] C0 = 32'hbfc00000;
  localparam logic [31:0] C4 = 32'hbfc00004;
  localparam logic [31:0] C8 = 32'hbfc00008;
  localparam logic [31:0] F1 = 32'hbfc00380;
  localparam logic [31:0] F2 = 32'hbfc00400;
  localparam logic [31:0] F3 = 32'hbfc00500;

  // random-phase model state
  logic        outstanding;
  int          delay;
  logic [31:0] resp_addr;
  logic [31:0] exp_pc;
  logic [31:0] pc_next;
  logic        prev_hold;
  logic [31:0] prev_addr;
  int          consumed;

  initial begin
    rst = 1'b1; pc_i = C0; stall_i = 1'b0; flush_i = 1'b0;
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0; inst_rdata_i = '0;

    //  rst pc   st fl ao dk rdata          | req addr rdy v  inst           ipc sreq chk
    add(1, C0, 0, 0, 0, 0, 32'h0,          0, C0, 0, 0, 32'h0,        C0, 1, 1);
    add(0, C0, 0, 0, 0, 0, 32'h0,          0, C0, 0, 0, 32'h0,        C0, 1, 0);
    add(0, C0, 0, 0, 1, 0, 32'h0,          1, C0, 1, 0, 32'h0,        C0, 1, 0);
    add(0, C4, 0, 0, 0, 1, 32'h24010001,   0, C0, 0, 0, 32'h0,        C0, 1, 0);
    for (int k = 0; k < 5; k++)
      add(0, C4, 1, 0, 0, 0, 32'h0,        0, C0, 0, 1, 32'h24010001, C0, 0, 1);
    add(0, C4, 0, 0, 0, 0, 32'h0,          0, C0, 0, 1, 32'h24010001, C0, 0, 1);
    for (int k = 0; k < 3; k++)
      add(0, C4, 0, 0, 0, 0, 32'h0,        1, C4, 0, 0, 32'h0,        C0, 1, 0);
    add(0, C4, 0, 0, 1, 0, 32'h0,          1, C4, 1, 0, 32'h0,        C0, 1, 0);
    add(0, C8, 0, 1, 0, 0, 32'h0,          0, C4, 0, 0, 32'h0,        C0, 0, 0);
    add(0, F1, 0, 0, 0, 1, 32'hdeadbeef,   0, C4, 0, 0, 32'h0,        C0, 1, 0);
    add(0, F1, 0, 0, 0, 0, 32'h0,          0, C4, 0, 0, 32'h0,        C0, 1, 0);
    add(0, F1, 0, 0, 1, 0, 32'h0,          1, F1, 1, 0, 32'h0,        C0, 1, 0);
    add(0, F1 + 4, 0, 1, 0, 1, 32'h11111111, 0, F1, 0, 0, 32'h0,      C0, 0, 0);
    add(0, F2, 0, 0, 0, 0, 32'h0,          0, F1, 0, 0, 32'h0,        C0, 1, 0);
    add(0, F2, 0, 0, 1, 0, 32'h0,          1, F2, 1, 0, 32'h0,        C0, 1, 0);
    add(0, F2 + 4, 0, 0, 0, 1, 32'h22222222, 0, F2, 0, 0, 32'h0,      C0, 1, 0);
    add(0, F2 + 4, 0, 1, 0, 0, 32'h0,      0, F2, 0, 1, 32'h22222222, F2, 0, 1);
    add(0, F3, 0, 0, 0, 0, 32'h0,          0, F2, 0, 0, 32'h0,        C0, 1, 0);
    add(0, F3, 0, 0, 0, 0, 32'h0,          1, F3, 0, 0, 32'h0,        C0, 1, 0);
    add(0, F3, 0, 0, 0, 0, 32'h0,          1, F3, 0, 0, 32'h0,        C0, 1, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; pc_i = vecs[i].pc; stall_i = vecs[i].stall; flush_i = vecs[i].flush;
      inst_addr_ok_i = vecs[i].aok; inst_data_ok_i = vecs[i].dok; inst_rdata_i = vecs[i].rdata;
      #1;
      check($sformatf("row%0d_req", i), inst_req_o, vecs[i].e_req);
      check($sformatf("row%0d_addr", i), inst_addr_o, vecs[i].e_addr);
      check($sformatf("row%0d_ready", i), pc_read_ready_o, vecs[i].e_rdy);
      check($sformatf("row%0d_valid", i), inst_valid_o, vecs[i].e_valid);
      check($sformatf("row%0d_stallreq", i), stallreq_o, vecs[i].e_sreq);
      check($sformatf("row%0d_exc", i), excepttype_o, 32'h0);
      if (vecs[i].chk_data) begin
        check($sformatf("row%0d_inst", i), inst_o, vecs[i].e_inst);
        check($sformatf("row%0d_ipc", i), inst_pc_o, vecs[i].e_ipc);
      end
      $display("row %0d: req=%0b addr=%08h rdy=%0b valid=%0b inst=%08h ipc=%08h",
               i, inst_req_o, inst_addr_o, pc_read_ready_o, inst_valid_o, inst_o, inst_pc_o);
    end

    // Misaligned PC sequence
    @(negedge clk);
    rst = 1'b1; pc_i = 32'hbfc00002; stall_i = 1'b0; flush_i = 1'b0;
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 check("mis_idle_req", inst_req_o, 1'b0);
    @(negedge clk);
    inst_addr_ok_i = 1'b1;
    #1;
`ifdef IF_ALIGN_CHECK_EN
    check("mis_req", inst_req_o, 1'b0);
    check("mis_ready", pc_read_ready_o, 1'b0);
    check("mis_valid", inst_valid_o, 1'b1);
    check("mis_exc", excepttype_o, 32'h00000010);
    check("mis_ipc", inst_pc_o, 32'hbfc00002);
    check("mis_inst", inst_o, 32'h0);
`else
    check("mis_req", inst_req_o, 1'b1);
    check("mis_addr", inst_addr_o, 32'hbfc00002);
    check("mis_ready", pc_read_ready_o, 1'b1);
    @(negedge clk);
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = 32'h3c000000;
    @(negedge clk);
    inst_data_ok_i = 1'b0; stall_i = 1'b1;
    #1;
    check("mis_valid", inst_valid_o, 1'b1);
    check("mis_exc", excepttype_o, 32'h0);
    check("mis_ipc", inst_pc_o, 32'hbfc00002);
    check("mis_inst", inst_o, 32'h3c000000);
`endif
    $display("misaligned seq: req=%0b valid=%0b exc=%08h ipc=%08h",
             inst_req_o, inst_valid_o, excepttype_o, inst_pc_o);

    // Randomized run
    @(negedge clk);
    rst = 1'b1; pc_i = C0; stall_i = 1'b0; flush_i = 1'b0;
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    outstanding = 1'b0; delay = 0; resp_addr = '0;
    exp_pc = C0; pc_next = C0; prev_hold = 1'b0; prev_addr = '0; consumed = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      pc_i           = pc_next;
      inst_addr_ok_i = inst_req_o && ($urandom_range(0, 2) == 0);
      inst_data_ok_i = outstanding && (delay == 0);
      inst_rdata_i   = inst_data_ok_i ? mem_word(resp_addr) : $urandom;
      stall_i        = ($urandom_range(0, 3) == 0);
      flush_i        = ($urandom_range(0, 14) == 0);
      #1;
      check("rnd_ready", pc_read_ready_o, inst_req_o && inst_addr_ok_i);
      check("rnd_stallreq", stallreq_o, !inst_valid_o && !flush_i);
      check("rnd_exc", excepttype_o, 32'h0);
      if (outstanding) check("rnd_one_outstanding", inst_req_o, 1'b0);
      if (prev_hold) begin
        check("rnd_req_held", inst_req_o, 1'b1);
        check("rnd_addr_stable", inst_addr_o, prev_addr);
      end
      if (inst_valid_o && !stall_i && !flush_i) begin
        check("rnd_ipc", inst_pc_o, exp_pc);
        check("rnd_inst", inst_o, mem_word(exp_pc));
        $display("fetch %0d: pc=%08h inst=%08h", consumed, inst_pc_o, inst_o);
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end

      prev_hold = inst_req_o && !inst_addr_ok_i && !flush_i;
      prev_addr = inst_addr_o;
      if (inst_addr_ok_i) begin
        outstanding = 1'b1;
        resp_addr   = inst_addr_o;
        delay       = $urandom_range(0, 2);
      end else if (inst_data_ok_i) begin
        outstanding = 1'b0;
      end else if (outstanding && delay > 0) begin
        delay--;
      end
      if (flush_i) begin
        pc_next = {16'hbfc0, 14'($urandom), 2'b00};
        exp_pc  = pc_next;
      end else if (pc_read_ready_o) begin
        pc_next = pc_i + 32'd4;
      end
    end
    check("rnd_liveness", 32'(consumed >= 50), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction-fetch sequencer between the PC register and the SRAM-like instruction bus. It takes the current fetch address from the PC register and issues one bus request at a time. It tells the PC register when the address has been accepted, so the PC can advance. It delivers the returned word, tagged with its PC, to the IF/ID stage, and discards a response still outstanding when a flush occurs.

## Interface
Parameters:
- `RESET_PC`, 32'hbfc00000: value of `inst_pc_o` and `inst_addr_o` out of reset.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `pc_i` in 32: current fetch address from the PC register.
- `pc_read_ready_o` out 1: address accepted by the bus this cycle; the PC register advances.
- `stall_i` in 1: IF/ID not accepting (from CTRL).
- `flush_i` in 1: pipeline flush (exception or redirect).
- `inst_req_o` out 1: bus request.
- `inst_addr_o` out 32: bus address.
- `inst_addr_ok_i` in 1: bus accepted the address.
- `inst_data_ok_i` in 1: bus read data valid.
- `inst_rdata_i` in 32: bus read data.
- `inst_o` out 32: fetched instruction.
- `inst_pc_o` out 32: PC of `inst_o`.
- `inst_valid_o` out 1: `inst_o` is valid; it is consumed in any cycle where `inst_valid_o && !stall_i`.
- `stallreq_o` out 1: fetch stall request to CTRL.
- `excepttype_o` out 32: exception bits travelling with `inst_o`.

## Operation
The block is a state machine with four states, plus a `discard` flag. At most one request is outstanding at any time.

- **IDLE**
  - Entered out of reset and after a flush.
  - Next cycle always goes to REQ, unless `flush_i` is high, in which case it stays in IDLE.
  - `stall_i` is ignored here. This avoids a deadlock, because CTRL's stall includes `stallreq_o`.
- **Entry to REQ**
  - `inst_addr_o` is latched from `pc_i`.
  - `inst_addr_o` stays stable for the whole time the block is in REQ.
- **REQ**
  - `inst_req_o` = 1.
  - `pc_read_ready_o` = (REQ && `inst_addr_ok_i`). This is combinational.
  - On `inst_addr_ok_i`, go to WAIT.
  - Flush without `inst_addr_ok_i`: withdraw the request and go to IDLE.
  - Flush in the same cycle as `inst_addr_ok_i`: go to WAIT with `discard` = 1.
- **WAIT**
  - `inst_req_o` = 0.
  - On `inst_data_ok_i` with `discard` = 0 and no flush: register `inst_rdata_i` into `inst_o` and the latched address into `inst_pc_o`, then go to HOLD.
  - On `inst_data_ok_i` with `discard` = 1, or with `flush_i` high: drop the data, clear `discard`, and go to IDLE.
  - `flush_i` without `inst_data_ok_i`: set `discard` and stay in WAIT.
- **HOLD**
  - `inst_valid_o` = 1; `inst_o`, `inst_pc_o` and `excepttype_o` are held stable.
  - If `!stall_i`: the word is consumed; clear valid and go to REQ.
  - If `flush_i`: clear valid and go to IDLE. Flush has priority over consumption.
- **stallreq_o** = !`inst_valid_o` && !`flush_i`.
- **excepttype_o**: zero, except for bit 4 (see Configuration). It is cleared whenever valid clears.
- **Reset**
  - Forces IDLE and `discard` = 0.
  - `inst_req_o`, `inst_valid_o`, `excepttype_o` and `inst_o` reset to 0.
  - `inst_pc_o` and `inst_addr_o` reset to `RESET_PC`.
  - Reset applied mid-transaction abandons the transaction. The bus is reset in the same cycle.

## Timing
- **Zero-wait bus** (`addr_ok` in the REQ cycle, `data_ok` in the cycle after): three cycles per instruction, REQ, WAIT, HOLD.
- **Back-to-back fetch:** `pc_read_ready_o` causes `pc_i` to update at the edge that leaves REQ. `pc_i` is therefore already the next address when the next REQ entry latches it.
- **Valid timing:** `inst_valid_o` rises on the edge after `inst_data_ok_i` and falls on the edge after the cycle in which the word is consumed.
- **Flush recovery:** IDLE lasts one cycle. REQ then latches `pc_i`, which by this point is the PC register's updated `new_pc`.

## Configuration
- **`IF_ALIGN_CHECK_EN` defined:**
  - On REQ entry, if `pc_i[1:0]` != 0, no bus request is issued and `pc_read_ready_o` stays 0.
  - The block goes directly to HOLD with `inst_o` = 0 (nop), `inst_pc_o` = `pc_i`, and `excepttype_o[4]` = 1 (AdEL, instruction fetch).
  - The resulting exception flush redirects the PC.
- **`IF_ALIGN_CHECK_EN` undefined:**
  - Any address is issued unchanged.
  - `excepttype_o[4]` is tied to 0.

## Test plan
- **Reset then zero-wait fetch:** release `rst`, `pc_i` = bfc00000, `inst_rdata_i` = 24010001 -> `inst_req_o` with `inst_addr_o` = bfc00000 one cycle after IDLE, `pc_read_ready_o` pulses once, and `inst_valid_o` = 1 with `inst_o` = 24010001 and `inst_pc_o` = bfc00000 one cycle after `data_ok`.
- **Addr_ok wait states:** `addr_ok` delayed 3 cycles -> `inst_req_o` and `inst_addr_o` held stable for 4 cycles, `pc_read_ready_o` asserted only in the 4th, `stallreq_o` = 1 throughout.
- **Downstream stall:** `stall_i` = 1 for 5 cycles during HOLD -> `inst_o` and `inst_pc_o` stable, no new `inst_req_o`; `stall_i` = 0 -> next REQ latches `pc_i` = bfc00004.
- **Flush in WAIT:** `flush_i` pulses before `data_ok` and `pc_i` becomes bfc00380 -> the stale `data_ok` word is dropped (`inst_valid_o` stays 0), then a request to bfc00380 is issued.
- **Simultaneous flush and data_ok in WAIT / flush and consume in HOLD:** in both cases -> no valid output, state returns to IDLE.
- **With `IF_ALIGN_CHECK_EN`, `pc_i` = bfc00002:** no `inst_req_o`; `inst_valid_o` = 1 with `excepttype_o` = 00000010 and `inst_pc_o` = bfc00002. Without the macro -> a request to bfc00002 is issued and `excepttype_o` = 0.
